// File: rtl/arinc_rd_sched.sv
// Read scheduler for NCH ARINC 429 receiver RAMs: tracks per-channel word counts,
// picks channels round-robin, reads each 32-bit word as two 16-bit halves and presents it.
module arinc_rd_sched #(
  parameter int NCH    = 4,
  parameter int RD_LAT = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] rx_done,
  output logic [2:0]     ch_sel,
  output logic [4:0]     rdaddress,
  input  logic [15:0]    q,
  output logic [31:0]    out_data,
  output logic [2:0]     out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [NCH-1:0] ovf,
  input  logic [NCH-1:0] ovf_clr
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_LO = 3'd1;
  localparam logic [2:0] RD_HI = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  logic [2:0]        state_reg;
  logic [2:0]        ch_sel_reg;
  logic [2:0]        out_ch_reg;
  logic [2:0]        last_reg;
  logic              out_valid_reg;
  logic [31:0]       out_data_reg;
  logic [RD_LAT-1:0] lo_sr_reg;
  logic [RD_LAT-1:0] hi_sr_reg;

  // Padded to 8 entries so a 3-bit channel index is always in range.
  logic [7:0][3:0]   rd_ptr_vec;
  logic [7:0][4:0]   pend_vec;
  logic [7:0]        pend_nz;

  logic              hs;
  logic              sel_found;
  logic [2:0]        sel_ch;
  logic [2:0]        cand;

  assign hs = (state_reg == OUT) && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      if (gi < NCH) begin : g_act
        logic [3:0] wr_ptr_reg;
        logic [3:0] rd_ptr_reg;
        logic [4:0] pend_reg;
        logic       ovf_reg;
        logic       push;
        logic       pop;
        logic       busy;
        logic       ovf_evt;

        assign push    = rx_done[gi];
        assign pop     = hs && (ch_sel_reg == 3'(gi));
        assign busy    = (state_reg != IDLE) && (ch_sel_reg == 3'(gi));
        assign ovf_evt = push && !pop && (pend_reg == 5'd16);

        always_ff @(posedge clock or negedge reset) begin
          if (!reset) begin
            wr_ptr_reg <= 4'd0;
            rd_ptr_reg <= 4'd0;
            pend_reg   <= 5'd0;
            ovf_reg    <= 1'b0;
          end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 4'd1;
            // The oldest word is dropped on overflow unless it is the one in flight.
            if (pop || (ovf_evt && !busy)) rd_ptr_reg <= rd_ptr_reg + 4'd1;
            if (push && !pop && (pend_reg != 5'd16)) pend_reg <= pend_reg + 5'd1;
            else if (pop && !push) pend_reg <= pend_reg - 5'd1;
            if (ovf_evt) ovf_reg <= 1'b1;
            else if (ovf_clr[gi]) ovf_reg <= 1'b0;
          end
        end

        assign rd_ptr_vec[gi] = rd_ptr_reg;
        assign pend_vec[gi]   = pend_reg;
        assign ovf[gi]        = ovf_reg;
      end else begin : g_pad
        assign rd_ptr_vec[gi] = 4'd0;
        assign pend_vec[gi]   = 5'd0;
      end
      assign pend_nz[gi] = |pend_vec[gi];
    end
  endgenerate

  always_comb begin
    sel_found = 1'b0;
    sel_ch    = 3'd0;
    cand      = 3'd0;
    for (int k = 1; k <= NCH; k++) begin
      cand = 3'((int'(last_reg) + k) % NCH);
      if (!sel_found && pend_nz[cand]) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end
  end

  always_comb begin
    rdaddress = 5'd0;
    if (state_reg == RD_LO)      rdaddress = {rd_ptr_vec[ch_sel_reg], 1'b0};
    else if (state_reg == RD_HI) rdaddress = {rd_ptr_vec[ch_sel_reg], 1'b1};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ch_sel_reg    <= 3'd0;
      out_ch_reg    <= 3'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 32'd0;
      last_reg      <= 3'(NCH - 1);
      lo_sr_reg     <= '0;
      hi_sr_reg     <= '0;
    end else begin
      // Token pipes mark the cycle in which each half arrives on q.
      lo_sr_reg <= (lo_sr_reg << 1) | RD_LAT'(state_reg == RD_LO);
      hi_sr_reg <= (hi_sr_reg << 1) | RD_LAT'(state_reg == RD_HI);
      if (lo_sr_reg[RD_LAT-1]) out_data_reg[15:0]  <= q;
      if (hi_sr_reg[RD_LAT-1]) out_data_reg[31:16] <= q;

      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            ch_sel_reg <= sel_ch;
            state_reg  <= RD_LO;
          end
        end
        RD_LO: state_reg <= RD_HI;
        RD_HI: state_reg <= WAIT;
        WAIT: begin
          if (hi_sr_reg[RD_LAT-1]) begin
            state_reg     <= OUT;
            out_valid_reg <= 1'b1;
            out_ch_reg    <= ch_sel_reg;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            last_reg      <= ch_sel_reg;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ch_sel    = ch_sel_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: doc/arinc_rd_sched.md
ARINC_RD_SCHED -- requirements
Module: arinc_rd_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of ARINC 429 receiver channels (2..8).
REQ-002 SHALL have parameter RD_LAT, default 2, clock cycles from rdaddress change to valid q from the receiver RAM (1..3).
REQ-003 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_done  input  NCH  one-cycle pulse per channel; one new 32-bit word written into that channel's RAM.
REQ-006 SHALL have port ch_sel  output  3  channel whose RAM q is routed to the q input by the external mux.
REQ-007 SHALL have port rdaddress  output  5  RAM read address; {word_ptr[3:0], half}, half 0 = bits[15:0], half 1 = bits[31:16].
REQ-008 SHALL have port q  input  16  muxed RAM read data.
REQ-009 SHALL have port out_data  output  32  assembled ARINC word.
REQ-010 SHALL have port out_ch  output  3  source channel of out_data.
REQ-011 SHALL have port out_valid  output  1  out_data/out_ch valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-013 SHALL have port ovf  output  NCH  sticky per-channel overflow flags.
REQ-014 SHALL have port ovf_clr  input  NCH  one-cycle clear of the matching ovf bit.

Function
REQ-015 SHALL keep, per channel, a 4-bit wr_ptr, a 4-bit rd_ptr and a 5-bit pending count (0..16).
REQ-016 SHALL, on rx_done[i], increment wr_ptr[i] (wrapping 15->0) and pending[i]; pending SHALL saturate at 16.
REQ-017 SHALL, on rx_done[i] with pending[i]=16 and no pop of channel i in the same cycle, advance rd_ptr[i] by 1 and set ovf[i].
REQ-018 SHALL suppress the REQ-017 rd_ptr advance while channel i is the channel being read (RD_LO..OUT); ovf[i] SHALL still be set.
REQ-019 SHALL leave pending[i] unchanged when a push and a pop of channel i occur in the same cycle.
REQ-020 SHALL use FSM states IDLE, RD_LO, RD_HI, WAIT, OUT.
REQ-021 IDLE: if any pending>0, SHALL round-robin select the lowest-index pending channel after the last served channel, latch it into ch_sel, and go to RD_LO; otherwise stay in IDLE.
REQ-022 RD_LO: SHALL drive rdaddress={rd_ptr[ch],0} for 1 cycle, then go to RD_HI.
REQ-023 RD_HI: SHALL drive rdaddress={rd_ptr[ch],1} for 1 cycle, then go to WAIT.
REQ-024 SHALL capture q into out_data[15:0] exactly RD_LAT cycles after the RD_LO cycle, and into out_data[31:16] exactly RD_LAT cycles after the RD_HI cycle.
REQ-025 WAIT: SHALL go to OUT on the cycle after the upper-half capture.
REQ-026 OUT: SHALL hold out_valid=1 with out_data and out_ch stable until out_ready=1.
REQ-027 SHALL, on the OUT handshake cycle, pop: increment rd_ptr[ch] (wrap) and decrement pending[ch], drop out_valid, record ch as last served, and return to IDLE.
REQ-028 SHALL hold ch_sel constant from RD_LO through OUT.
REQ-029 SHALL give ovf_clr[i] and a new overflow event in the same cycle the result ovf[i]=1.
REQ-030 A new word is issued no sooner than RD_LAT+4 cycles after the previous word was accepted.

Reset
REQ-031 SHALL, while reset=0, force state IDLE, all pointers and pending counts to 0, ch_sel=0, rdaddress=0, out_data=0, out_ch=0, out_valid=0, ovf=0, and last served = NCH-1 (channel 0 is served first).
REQ-032 SHALL discard any transfer in progress when reset is asserted, and SHALL not present the discarded word after reset is released.

Verification
REQ-033 Single word: one rx_done[2] pulse, q model returns 16'h1234 at address 0 and 16'hABCD at address 1 -> rdaddress 0 then 1, out_data=32'hABCD1234, out_ch=2, out_valid asserted RD_LAT+2 cycles after RD_LO.
REQ-034 Round robin: ch0 and ch1 each hold 2 words, out_ready=1 -> out_ch order 0,1,0,1.
REQ-035 Backpressure: out_ready=0 for 10 cycles during OUT -> out_valid, out_data and out_ch stable; pending drops by 1 only on the handshake cycle.
REQ-036 Overflow: 17 rx_done[0] pulses with out_ready=0 and no reads started -> pending[0]=16, ovf[0]=1, rd_ptr[0]=1; a later ovf_clr[0] -> ovf[0]=0.
REQ-037 Wrap: 20 words on ch3, drained as they arrive -> rdaddress word field wraps 15->0, and all 20 words are delivered in order.
REQ-038 Reset mid-transfer: reset=0 in RD_HI -> out_valid=0 and pending=0 immediately; after release, out_valid stays 0 until a new rx_done arrives.
